// File: rtl/centroid_reader.sv
// Centroid readback engine: sweeps object ids through the labeler query port and
// streams (id, x, y) records out through a credit-protected first-word-fall-through FIFO.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | presenting ids to the labeler while FIFO credits allow
// DRAIN  | every id issued; waiting for reads to land and the FIFO to empty
// FINISH | sweep complete; done pulses on the following cycle
module centroid_reader #(
    parameter int WORD_SIZE    = 8,
    parameter int COORD_WIDTH  = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   num_labels,
    output logic [WORD_SIZE-1:0]   obj_id,
    input  logic [COORD_WIDTH-1:0] obj_x,
    input  logic [COORD_WIDTH-1:0] obj_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_SIZE-1:0]   out_id,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic                   busy,
    output logic                   done
);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int REC_W = WORD_SIZE + 2 * COORD_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] next_id;
    logic [WORD_SIZE-1:0] last_id;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     inflight;
    logic                 issue;
    logic                 cap_valid;
    logic [WORD_SIZE-1:0] cap_id;
    logic                 wr_en;
    logic                 rd_en;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [REC_W-1:0]     mem [FIFO_DEPTH];
    logic [REC_W-1:0]     head;

    // Every queued record and every read still in flight holds one FIFO slot.
    assign obj_id = next_id;
    assign issue  = (state == ISSUE) && ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));

    if (READ_LATENCY == 0) begin : g_comb_read
        assign cap_valid = issue;
        assign cap_id    = next_id;
        assign inflight  = '0;
    end else begin : g_tag_pipe
        logic [READ_LATENCY-1:0] tag_valid;
        logic [WORD_SIZE-1:0]    tag_id [READ_LATENCY];

        always_ff @(posedge clk) begin
            if (reset) begin
                tag_valid <= '0;
            end else begin
                tag_valid[0] <= issue;
                for (int k = 1; k < READ_LATENCY; k++) tag_valid[k] <= tag_valid[k-1];
            end
        end

        always_ff @(posedge clk) begin
            tag_id[0] <= next_id;
            for (int k = 1; k < READ_LATENCY; k++) tag_id[k] <= tag_id[k-1];
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < READ_LATENCY; k++) inflight = inflight + CNT_W'(tag_valid[k]);
        end

        assign cap_valid = tag_valid[READ_LATENCY-1];
        assign cap_id    = tag_id[READ_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            next_id <= '0;
            last_id <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the old sweep.
                    if (start && !done) begin
                        busy    <= 1'b1;
                        last_id <= num_labels - WORD_SIZE'(1);
                        if (num_labels <= WORD_SIZE'(1)) begin
                            state <= FINISH;
                        end else begin
                            next_id <= WORD_SIZE'(1);
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        next_id <= next_id + WORD_SIZE'(1);
                        if (next_id == last_id) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_count == '0) state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign wr_en = cap_valid;
    assign rd_en = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {cap_id, obj_x, obj_y};
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_id    = out_valid ? head[REC_W-1 -: WORD_SIZE]       : '0;
    assign out_x     = out_valid ? head[2*COORD_WIDTH-1 -: COORD_WIDTH] : '0;
    assign out_y     = out_valid ? head[COORD_WIDTH-1:0]            : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_centroid_reader.sv
// Bench for centroid_reader: four instances (read latency 1, 0, 2, 4) share stimulus;
// a negedge monitor checks every transferred record against a shared expected queue.
`timescale 1ns/1ps
module tb_centroid_reader;
    localparam int N = 4;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  num_labels = 8'd0;

    logic [7:0]  obj_id_a    [N];
    logic [15:0] obj_x_a     [N];
    logic [15:0] obj_y_a     [N];
    logic        out_valid_a [N];
    logic [7:0]  out_id_a    [N];
    logic [15:0] out_x_a     [N];
    logic [15:0] out_y_a     [N];
    logic        busy_a      [N];
    logic        done_a      [N];

    rec_t exp_q [$];
    int   rd_idx   [N];
    int   done_cnt [N];
    int   xfer_cnt [N];
    int   snap     [N];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 2 : 4;
        localparam int DEP = (g == 3) ? 8 : 4;
        logic [7:0] hist [5];
        logic [7:0] rd_addr;

        // labeler model: x = 10*id, y = 20*id, returned LAT cycles after obj_id
        always @(posedge clk) begin
            hist[0] <= obj_id_a[g];
            for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
        end
        if (LAT == 0) begin : g_l0
            assign rd_addr = obj_id_a[g];
        end else begin : g_ln
            assign rd_addr = hist[LAT-1];
        end
        assign obj_x_a[g] = 16'(rd_addr) * 16'd10;
        assign obj_y_a[g] = 16'(rd_addr) * 16'd20;

        centroid_reader #(
            .WORD_SIZE(8), .COORD_WIDTH(16), .READ_LATENCY(LAT), .FIFO_DEPTH(DEP)
        ) dut (
            .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
            .obj_id(obj_id_a[g]), .obj_x(obj_x_a[g]), .obj_y(obj_y_a[g]),
            .out_valid(out_valid_a[g]), .out_ready(out_ready),
            .out_id(out_id_a[g]), .out_x(out_x_a[g]), .out_y(out_y_a[g]),
            .busy(busy_a[g]), .done(done_a[g])
        );
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rd_idx[i] = 0; done_cnt[i] = 0; xfer_cnt[i] = 0; snap[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                rd_idx[i] = exp_q.size();
            end else begin
                if (done_a[i]) done_cnt[i]++;
                if (out_valid_a[i] && out_ready) begin
                    xfer_cnt[i]++;
                    checks++;
                    if (rd_idx[i] >= exp_q.size()) begin
                        errors++;
                        $display("FAIL record inst%0d unexpected: got (%0d,%0d,%0d) expected none",
                                 i, out_id_a[i], out_x_a[i], out_y_a[i]);
                    end else begin
                        if ({out_id_a[i], out_x_a[i], out_y_a[i]} !== exp_q[rd_idx[i]]) begin
                            errors++;
                            $display("FAIL record inst%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                     i, out_id_a[i], out_x_a[i], out_y_a[i], exp_q[rd_idx[i]].id,
                                     exp_q[rd_idx[i]].x, exp_q[rd_idx[i]].y);
                        end
                        rd_idx[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(req));
        end
    endtask

    task automatic push_sweep(input int n);
        rec_t r;
        for (int id = 1; id < n; id++) begin
            r.id = 8'(id);
            r.x  = 16'(10 * id);
            r.y  = 16'(20 * id);
            exp_q.push_back(r);
        end
    endtask

    task automatic pulse_start(input int n);
        for (int i = 0; i < N; i++) snap[i] = done_cnt[i];
        num_labels = 8'(n);
        start = 1'b1;
        push_sweep(n);
        tick();
        start = 1'b0;
    endtask

    task automatic finish_sweep(input string name, input int budget, input bit rand_ready);
        bit all_done;
        int t;
        t = 0;
        all_done = 1'b0;
        while (!all_done && t < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
            all_done = 1'b1;
            for (int i = 0; i < N; i++) if (done_cnt[i] == snap[i]) all_done = 1'b0;
        end
        out_ready = 1'b1;
        check({name, " completes in budget"}, 32'(all_done), 32'd1);
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s inst%0d single done", name, i), done_cnt[i], snap[i] + 1);
            check($sformatf("%s inst%0d all records", name, i), rd_idx[i], exp_q.size());
        end
    endtask

    initial begin
        int first, last, nv, t, base;
        bit seen, busy_prev, unstable;
        int snapd [N];

        repeat (3) tick();
        check("reset obj_id", 32'(obj_id_a[0]), 0);
        check("reset busy", 32'(busy_a[0]), 0);
        check("reset done", 32'(done_a[0]), 0);
        check("reset out_valid", 32'(out_valid_a[0]), 0);
        check("reset out_id", 32'(out_id_a[0]), 0);
        check("reset out_x", 32'(out_x_a[0]), 0);
        check("reset out_y", 32'(out_y_a[0]), 0);
        reset = 1'b0;
        tick();

        // basic sweep, records 1..3 back to back
        out_ready = 1'b1;
        pulse_start(4);
        first = -1; last = -1; nv = 0; t = 1; seen = 1'b0; busy_prev = 1'b0;
        while (!seen && t < 40) begin
            if (out_valid_a[0]) begin
                if (first < 0) first = t;
                last = t;
                nv++;
            end
            if (done_a[0]) begin
                seen = 1'b1;
                check("basic busy low with done", 32'(busy_a[0]), 0);
            end else begin
                busy_prev = busy_a[0];
                tick();
                t++;
            end
        end
        check("basic done seen", 32'(seen), 1);
        check("basic busy before done", 32'(busy_prev), 1);
        check("basic first record cycle", first, 3);
        check("basic record cycles", nv, 3);
        check("basic contiguous", last - first, 2);
        finish_sweep("basic", 50, 1'b0);

        // empty frame, plus a start landing on the done cycle
        pulse_start(1);
        check("empty busy c1", 32'(busy_a[0]), 1);
        check("empty done c1", 32'(done_a[0]), 0);
        tick();
        check("empty done c2", 32'(done_a[0]), 1);
        check("empty busy c2", 32'(busy_a[0]), 0);
        num_labels = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start on done ignored", 32'(busy_a[0]), 0);
        tick();
        check("start on done stays idle", 32'(busy_a[0]), 0);
        finish_sweep("empty", 20, 1'b0);

        // backpressure
        out_ready = 1'b0;
        pulse_start(10);
        unstable = 1'b0;
        repeat (19) begin
            tick();
            if (out_valid_a[0] && (out_id_a[0] != 8'd1 || out_x_a[0] != 16'd10 || out_y_a[0] != 16'd20))
                unstable = 1'b1;
        end
        check("bp obj_id stalled", 32'(obj_id_a[0]), 5);
        check("bp out_valid", 32'(out_valid_a[0]), 1);
        check("bp head id", 32'(out_id_a[0]), 1);
        check("bp head x", 32'(out_x_a[0]), 10);
        check("bp head y", 32'(out_y_a[0]), 20);
        check("bp head stable", 32'(unstable), 0);
        check("bp no transfers", xfer_cnt[0], 3);
        out_ready = 1'b1;
        finish_sweep("backpressure", 100, 1'b0);

        // random ready, long sweep
        pulse_start(200);
        finish_sweep("random", 3000, 1'b1);

        // saturation: ids 1..254
        pulse_start(255);
        finish_sweep("saturation", 1000, 1'b0);

        // reset mid-sweep
        base = xfer_cnt[0];
        pulse_start(50);
        t = 0;
        while ((xfer_cnt[0] - base) < 10 && t < 100) begin
            tick();
            t++;
        end
        check("midreset ten records", 32'((xfer_cnt[0] - base) >= 10), 1);
        reset = 1'b1;
        for (int i = 0; i < N; i++) snapd[i] = done_cnt[i];
        tick();
        check("midreset out_valid", 32'(out_valid_a[0]), 0);
        check("midreset busy", 32'(busy_a[0]), 0);
        check("midreset obj_id", 32'(obj_id_a[0]), 0);
        check("midreset done", 32'(done_a[0]), 0);
        reset = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < N; i++)
            check($sformatf("midreset inst%0d no done", i), done_cnt[i], snapd[i]);
        pulse_start(3);
        finish_sweep("after reset", 50, 1'b0);

        // start while busy is ignored
        pulse_start(5);
        tick();
        check("busy before restart", 32'(busy_a[0]), 1);
        num_labels = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_sweep("start while busy", 100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
